// File: rtl/fft_test_sys_pio_poller_if.sv
// Avalon-MM slave bundle for the PIO poller: word address, strobes, write data and registered read data.
interface fft_test_sys_pio_poller_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/fft_test_sys_pio_poller.sv
// Periodically samples a synchronized 16-bit input bus into a 4-entry FIFO drained through Avalon-MM reads.
// Optional PIO_POLL_TIMESTAMP_EN stores a 15-bit free-running cycle stamp with each entry (DATA bits 30:16).
module fft_test_sys_pio_poller (
  input  logic                            clk,
  input  logic                            reset,
  fft_test_sys_pio_poller_if.slave        avs,
  input  logic [15:0]                     in_port,
  output logic                            irq
);

  localparam logic [1:0] A_DATA    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_PERIOD  = 2'd2;
  localparam logic [1:0] A_CONTROL = 2'd3;

  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [15:0] r_period;
  logic [15:0] r_cnt;
  logic [15:0] r_last;
  logic        r_en;
  logic        r_co;
  logic        r_ie;
  logic        r_ovf;
  logic        r_irq;
  logic [31:0] r_readdata;
  logic [15:0] r_fifo [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;

  logic        w_wr_period;
  logic        w_wr_ctrl;
  logic        w_en_next;
  logic        w_ie_next;
  logic        w_en_rise;
  logic        w_tick;
  logic        w_push_req;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_ovf_next;
  logic [2:0]  w_count_next;
  logic [15:0] w_cnt_next;
  logic [14:0] w_head_ts;
  logic [31:0] w_rd_next;
  logic        w_irq_next;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^avs.writedata[31:16];

  assign w_wr_period = avs.write && (avs.address == A_PERIOD);
  assign w_wr_ctrl   = avs.write && (avs.address == A_CONTROL);
  assign w_en_next   = w_wr_ctrl ? avs.writedata[0] : r_en;
  assign w_ie_next   = w_wr_ctrl ? avs.writedata[2] : r_ie;
  assign w_en_rise   = w_wr_ctrl && !r_en && avs.writedata[0];

  // Tick comes from the registered enable/counter, so a write in the same cycle cannot cancel it.
  assign w_tick      = r_en && (r_cnt == r_period);
  assign w_push_req  = w_tick && !(r_co && (r_sync2 == r_last));
  assign w_full      = (r_count == 3'd4);
  assign w_pop       = avs.read && (avs.address == A_DATA) && (r_count != 3'd0);
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_set   = w_push_req && w_full && !w_pop;
  // Software clear beats a simultaneous drop so the clear is never lost.
  assign w_ovf_next  = (w_wr_ctrl && avs.writedata[8]) ? 1'b0 : (r_ovf | w_ovf_set);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 3'd1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 3'd1;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt + 16'd1;
    if (!w_en_next || w_wr_period || w_en_rise || w_tick) begin
      w_cnt_next = 16'd0;
    end
  end

  assign w_irq_next = w_ie_next && ((w_count_next != 3'd0) || w_ovf_next);

`ifdef PIO_POLL_TIMESTAMP_EN
  logic [14:0] r_ts;
  logic [14:0] r_fifo_ts [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= 15'd0;
    end else begin
      r_ts <= r_ts + 15'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo_ts[r_wptr] <= r_ts;
    end
  end

  assign w_head_ts = r_fifo_ts[r_rptr];
`else
  assign w_head_ts = 15'd0;
`endif

  always_comb begin
    w_rd_next = r_readdata;
    if (avs.read) begin
      unique case (avs.address)
        A_DATA:    w_rd_next = (r_count != 3'd0) ? {1'b1, w_head_ts, r_fifo[r_rptr]} : 32'd0;
        A_STATUS:  w_rd_next = {28'd0, r_ovf, r_count};
        A_PERIOD:  w_rd_next = {16'd0, r_period};
        A_CONTROL: w_rd_next = {29'd0, r_ie, r_co, r_en};
        default:   w_rd_next = 32'd0;
      endcase
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo[r_wptr] <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 16'd0;
      r_sync2    <= 16'd0;
      r_period   <= 16'd999;
      r_cnt      <= 16'd0;
      r_last     <= 16'd0;
      r_en       <= 1'b0;
      r_co       <= 1'b0;
      r_ie       <= 1'b0;
      r_ovf      <= 1'b0;
      r_irq      <= 1'b0;
      r_readdata <= 32'd0;
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_count    <= 3'd0;
    end else begin
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_cnt      <= w_cnt_next;
      r_ovf      <= w_ovf_next;
      r_irq      <= w_irq_next;
      r_readdata <= w_rd_next;
      r_count    <= w_count_next;
      if (w_wr_period) begin
        r_period <= avs.writedata[15:0];
      end
      if (w_wr_ctrl) begin
        r_en <= avs.writedata[0];
        r_co <= avs.writedata[1];
        r_ie <= avs.writedata[2];
      end
      if (w_push) begin
        r_wptr <= r_wptr + 2'd1;
        r_last <= r_sync2;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
    end
  end

  assign avs.readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_fft_test_sys_pio_poller.sv
// Randomized and directed bench for fft_test_sys_pio_poller against a queue-based reference model.
module tb_fft_test_sys_pio_poller;

`ifdef PIO_POLL_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif
  localparam logic [31:0] RD_MASK = TS_ON ? 32'h8000_FFFF : 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_port;
  logic        irq;

  fft_test_sys_pio_poller_if avs();

  fft_test_sys_pio_poller dut (
    .clk     (clk),
    .reset   (reset),
    .avs     (avs.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: FIFO held as a queue of {timestamp, sample}.
  logic [15:0] m_s1, m_s2, m_period, m_cnt, m_last;
  logic        m_en, m_co, m_ie, m_ovf, m_irq;
  logic [31:0] m_rd;
  logic [14:0] m_ts;
  logic [30:0] m_q[$];

  task automatic cyc(input logic rst, input logic [1:0] a, input logic rd, input logic wr,
                     input logic [31:0] wd, input logic [15:0] ip);
    logic tick, pop, push_req, old_en;
    logic [15:0] cnt_next;
    reset         = rst;
    avs.address   = a;
    avs.read      = rd;
    avs.write     = wr;
    avs.writedata = wd;
    in_port       = ip;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_period = 16'd999; m_cnt = 0; m_last = 0;
      m_en = 0; m_co = 0; m_ie = 0; m_ovf = 0; m_irq = 0; m_rd = 0; m_ts = 0;
      m_q.delete();
    end else begin
      if (rd) begin
        case (a)
          2'd0: m_rd = (m_q.size() > 0) ?
                       {1'b1, (TS_ON ? m_q[0][30:16] : 15'd0), m_q[0][15:0]} : 32'd0;
          2'd1: m_rd = {28'd0, m_ovf, 3'(m_q.size())};
          2'd2: m_rd = {16'd0, m_period};
          default: m_rd = {29'd0, m_ie, m_co, m_en};
        endcase
      end
      tick     = m_en && (m_cnt == m_period);
      pop      = rd && (a == 2'd0) && (m_q.size() > 0);
      push_req = tick && !(m_co && (m_s2 == m_last));
      if (pop) void'(m_q.pop_front());
      if (push_req) begin
        if (m_q.size() < 4) begin
          m_q.push_back({m_ts, m_s2});
          m_last = m_s2;
        end else begin
          m_ovf = 1'b1;
        end
      end
      old_en   = m_en;
      cnt_next = tick ? 16'd0 : m_cnt + 16'd1;
      if (wr && a == 2'd2) begin
        m_period = wd[15:0];
        cnt_next = 0;
      end
      if (wr && a == 2'd3) begin
        m_en = wd[0]; m_co = wd[1]; m_ie = wd[2];
        if (wd[8]) m_ovf = 1'b0;
        if (!old_en && wd[0]) cnt_next = 0;
      end
      if (!m_en) cnt_next = 0;
      m_cnt = cnt_next;
      m_irq = m_ie && ((m_q.size() != 0) || m_ovf);
      m_s2  = m_s1;
      m_s1  = ip;
      m_ts  = m_ts + 15'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] ip);
    cyc(1, 0, 0, 0, 0, ip);
    cyc(1, 0, 0, 0, 0, ip);
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; exp_rd[2] = 32'h3E7; exp_rd[3] = 32'h0;
    do_reset(16'h0);
    n_checks++;
    if (avs.readdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: readdata=%h irq=%b, required readdata=0 irq=0", avs.readdata, irq);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 2'(i), 1, 0, 0, 16'h0);
      n_checks++;
      if (avs.readdata !== exp_rd[i] || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read_addr%0d: readdata=%h irq=%b, required %h irq=0", i, avs.readdata, irq, exp_rd[i]);
      end
    end
  endtask

  task automatic test_periodic();
    bit done = 0;
    do_reset(16'h1234);
    cyc(0, 2, 0, 1, 32'd3, 16'h1234);
    cyc(0, 3, 0, 1, 32'd1, 16'h1234);
    for (int i = 0; i < 60 && !done; i++) begin
      cyc(0, 1, 1, 0, 0, 16'h1234);
      n_checks++;
      if (avs.readdata !== m_rd) begin
        n_fail++;
        $display("FAIL periodic_status_poll: readdata=%h, required %h", avs.readdata, m_rd);
      end
      if (avs.readdata[2:0] == 3'd4) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL periodic_fill_timeout: count never reached 4, last status=%h", avs.readdata);
    end
    cyc(0, 0, 1, 0, 0, 16'h1234);
    n_checks++;
    if ((avs.readdata & RD_MASK) !== 32'h8000_1234 || avs.readdata !== m_rd) begin
      n_fail++;
      $display("FAIL periodic_data: readdata=%h, required %h", avs.readdata, m_rd);
    end
  endtask

  task automatic test_change_only();
    logic [31:0] exp [3];
    exp[0] = 32'h2; exp[1] = 32'h8000_AAAA; exp[2] = 32'h8000_5555;
    do_reset(16'hAAAA);
    cyc(0, 2, 0, 1, 32'd0, 16'hAAAA);
    cyc(0, 3, 0, 1, 32'd3, 16'hAAAA);
    for (int i = 0; i < 18; i++) cyc(0, 0, 0, 0, 0, 16'hAAAA);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 16'h5555);
    cyc(0, 3, 0, 1, 32'd0, 16'h5555);
    cyc(0, 1, 1, 0, 0, 16'h5555);
    n_checks++;
    if (avs.readdata !== exp[0]) begin
      n_fail++;
      $display("FAIL change_only_count: status=%h, required %h", avs.readdata, exp[0]);
    end
    for (int i = 1; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 16'h5555);
      n_checks++;
      if ((avs.readdata & RD_MASK) !== exp[i]) begin
        n_fail++;
        $display("FAIL change_only_entry%0d: readdata=%h, required %h", i, avs.readdata, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(16'h00F0);
    cyc(0, 2, 0, 1, 32'd0, 16'h00F0);
    cyc(0, 3, 0, 1, 32'd1, 16'h00F0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 16'h00F0);
    cyc(0, 1, 1, 0, 0, 16'h00F0);
    n_checks++;
    if (avs.readdata !== 32'hC) begin
      n_fail++;
      $display("FAIL overflow_status: status=%h, required 0000000c", avs.readdata);
    end
    cyc(0, 3, 0, 1, 32'h101, 16'h00F0);
    cyc(0, 1, 1, 0, 0, 16'h00F0);
    n_checks++;
    if (avs.readdata !== 32'h4) begin
      n_fail++;
      $display("FAIL overflow_clear: status=%h, required 00000004", avs.readdata);
    end
    cyc(0, 3, 1, 0, 0, 16'h00F0);
    n_checks++;
    if (avs.readdata !== 32'h1) begin
      n_fail++;
      $display("FAIL overflow_ctrl_readback: control=%h, required 00000001", avs.readdata);
    end
  endtask

  task automatic test_full_pop_tick();
    logic [15:0] ip = 16'h0100;
    logic [15:0] oldest;
    int guard = 0;
    do_reset(ip);
    cyc(0, 2, 0, 1, 32'd0, ip++);
    cyc(0, 3, 0, 1, 32'd1, ip++);
    while (m_q.size() < 4 && guard < 20) begin
      cyc(0, 0, 0, 0, 0, ip++);
      guard++;
    end
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL full_pop_fill_timeout: model queue size=%0d, required 4", m_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      oldest = m_q[0][15:0];
      cyc(0, 0, 1, 0, 0, ip++);
      n_checks++;
      if (avs.readdata[15:0] !== oldest || avs.readdata[31] !== 1'b1 || avs.readdata !== m_rd) begin
        n_fail++;
        $display("FAIL full_pop_oldest%0d: readdata=%h, required %h", i, avs.readdata, m_rd);
      end
    end
    cyc(0, 1, 1, 0, 0, ip++);
    n_checks++;
    if (avs.readdata !== 32'h4) begin
      n_fail++;
      $display("FAIL full_pop_status: status=%h, required 00000004", avs.readdata);
    end
  endtask

  task automatic test_irq();
    do_reset(16'h00C3);
    cyc(0, 2, 0, 1, 32'd0, 16'h00C3);
    cyc(0, 3, 0, 1, 32'd5, 16'h00C3);
    cyc(0, 3, 0, 1, 32'd4, 16'h00C3);
    cyc(0, 0, 0, 0, 0, 16'h00C3);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_assert: irq=%b, required 1", irq);
    end
    cyc(0, 0, 1, 0, 0, 16'h00C3);
    cyc(0, 0, 0, 0, 0, 16'h00C3);
    n_checks++;
    if (irq !== 1'b0 || (avs.readdata & RD_MASK) !== 32'h8000_00C3) begin
      n_fail++;
      $display("FAIL irq_pop: irq=%b readdata=%h, required irq=0 readdata=800000c3", irq, avs.readdata);
    end
    cyc(0, 0, 1, 0, 0, 16'h00C3);
    n_checks++;
    if (avs.readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL irq_empty_read: readdata=%h, required 00000000", avs.readdata);
    end
  endtask

  task automatic test_random();
    logic [1:0]  a;
    logic        rd, wr;
    logic [31:0] wd;
    logic [15:0] ip = 16'h0;
    do_reset(ip);
    for (int i = 0; i < 3000; i++) begin
      a  = 2'($urandom_range(0, 3));
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 7) == 0);
      wd = $urandom;
      if (a == 2'd2) wd = 32'($urandom_range(0, 6));
      if (a == 2'd3) wd = {23'd0, wd[8], 5'd0, wd[2:0]};
      if ($urandom_range(0, 3) == 0) ip = 16'h1111 * 16'($urandom_range(0, 3));
      cyc(($urandom_range(0, 499) == 0), a, rd, wr, wd, ip);
      n_checks++;
      if (avs.readdata !== m_rd || irq !== m_irq) begin
        n_fail++;
        $display("FAIL random_cycle%0d: readdata=%h irq=%b, required readdata=%h irq=%b",
                 i, avs.readdata, irq, m_rd, m_irq);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 2, 0, 1, 32'd0, 16'h0777);
    cyc(0, 3, 0, 1, 32'd5, 16'h0777);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 16'h0777);
    cyc(1, 1, 1, 1, 32'd0, 16'h0777);
    n_checks++;
    if (avs.readdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: readdata=%h irq=%b, required 0 and 0", avs.readdata, irq);
    end
    cyc(0, 1, 1, 0, 0, 16'h0777);
    n_checks++;
    if (avs.readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_status: status=%h, required 00000000", avs.readdata);
    end
  endtask

  initial begin
    reset = 1'b1; avs.address = 0; avs.read = 0; avs.write = 0; avs.writedata = 0; in_port = 0;
    test_reset();
    test_periodic();
    test_change_only();
    test_overflow();
    test_full_pop_tick();
    test_irq();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_test_sys_pio_poller.md
FFT_TEST_SYS_PIO_POLLER -- requirements
Module: fft_test_sys_pio_poller

Interface
REQ-001 SHALL provide port: clk  input  1  single system clock; all logic rising-edge.
REQ-002 SHALL provide port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide port: address  input  2  Avalon-MM slave word address.
REQ-004 SHALL provide port: read  input  1  Avalon read strobe, one cycle per access.
REQ-005 SHALL provide port: write  input  1  Avalon write strobe.
REQ-006 SHALL provide port: writedata  input  32  Avalon write data.
REQ-007 SHALL provide port: readdata  output  32  registered read data, valid 1 cycle after read.
REQ-008 SHALL provide port: in_port  input  16  asynchronous external input bus being polled.
REQ-009 SHALL provide port: irq  output  1  level interrupt, registered.

Function
REQ-010 SHALL synchronize in_port through two flops; sample = second flop.
REQ-011 SHALL map registers: 0 DATA (read pops), 1 STATUS (RO), 2 PERIOD (RW, bits 15:0), 3 CONTROL (RW: bit0 enable, bit1 change_only, bit2 irq_en; writing bit8=1 clears overflow, self-clearing, reads 0).
REQ-012 SHALL run a 16-bit period counter when enable=1: counts 0..PERIOD, tick on cycle counter==PERIOD, then reloads 0; PERIOD=0 gives tick every cycle.
REQ-013 SHALL hold counter at 0 and generate no ticks while enable=0; a PERIOD write or enable 0->1 SHALL reset counter to 0.
REQ-014 On tick SHALL push sample into 4-entry FIFO, unless change_only=1 and sample equals last_pushed; last_pushed updates only on a successful push.
REQ-015 Push with FIFO full and no same-cycle pop SHALL drop the sample and set sticky overflow.
REQ-016 Same-cycle push and pop SHALL both succeed at any level, including full (count unchanged, no overflow).
REQ-017 DATA read SHALL return {1'b1, 15'b0, head} and pop when count>0; when empty SHALL return 0 and not pop.
REQ-018 STATUS read SHALL return {28'b0 field: overflow at bit3, count (0..4) at bits 2:0}; bit3 overflow, bits 2:0 count, rest 0.
REQ-019 Reads of PERIOD/CONTROL SHALL return stored values, unused bits 0; readdata SHALL hold its value when read=0.
REQ-020 Read and write same cycle SHALL both take effect; write to DATA/STATUS ignored.
REQ-021 irq SHALL be registered: irq_en & ((count!=0) | overflow), evaluated from post-update state.
REQ-022 FIFO pointers SHALL wrap modulo 4; count width 3 bits.

Reset
REQ-023 On reset SHALL set: readdata 0, irq 0, PERIOD 16'd999, CONTROL 0, counter 0, FIFO empty, overflow 0, last_pushed 0, synchronizer flops 0.
REQ-024 Reset mid-operation SHALL discard FIFO contents and any pending tick; reset dominates read/write in the same cycle.

Configuration
REQ-025 Macro PIO_POLL_TIMESTAMP_EN defined: SHALL keep a free-running 15-bit cycle counter (reset 0, wraps) stored alongside each FIFO entry and returned in DATA bits 30:16.
REQ-026 Macro PIO_POLL_TIMESTAMP_EN undefined: no timestamp logic; DATA bits 30:16 read 0.

Verification
REQ-027 Reset, read all four addresses -> 0x0, 0x0, 0x3E7, 0x0; irq 0.
REQ-028 PERIOD=3, enable=1, in_port=0x1234 constant -> push every 4 cycles; STATUS count reaches 4; DATA read returns 0x80001234 (timestamp bits 0 when macro undefined).
REQ-029 change_only=1, PERIOD=0, in_port 0xAAAA held 20 cycles then 0x5555 -> exactly 2 entries, 0xAAAA then 0x5555.
REQ-030 FIFO full, PERIOD=0, no reads -> STATUS=0xC; CONTROL write 0x101 -> STATUS=0x4, enable remains 1.
REQ-031 FIFO full, DATA read coincident with tick -> count stays 4, overflow stays 0, oldest entry returned.
REQ-032 irq_en=1, one entry queued -> irq 1; pop via DATA read -> irq 0 two cycles after read strobe; empty DATA read -> 0x00000000.
